// File: rtl/ghost_pkg.sv
// Shared types and keycode helpers for the ghost direction scheduler.
package ghost_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h07;
  localparam logic [7:0] KEY_RIGHT = 8'h16;
  localparam logic [7:0] KEY_DOWN  = 8'h1A;
  localparam logic [7:0] KEY_UP    = 8'h04;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  // Encoding chosen so a direction's reverse is the value with bit 0 flipped.
  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_D = 2'd2,
    DIR_U = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DECIDE = 2'd2,
    NEXT   = 2'd3
  } sched_state_e;

  function automatic logic [7:0] dir_to_key(input dir_e d);
    logic [7:0] k;
    case (d)
      DIR_L:   k = KEY_LEFT;
      DIR_R:   k = KEY_RIGHT;
      DIR_D:   k = KEY_DOWN;
      default: k = KEY_UP;
    endcase
    return k;
  endfunction

  // True when the keycode names one of the four directions.
  function automatic logic key_is_dir(input logic [7:0] k);
    return (k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_DOWN) || (k == KEY_UP);
  endfunction

  // Only meaningful when key_is_dir(k) is true.
  function automatic dir_e key_to_dir(input logic [7:0] k);
    dir_e d;
    case (k)
      KEY_RIGHT: d = DIR_R;
      KEY_DOWN:  d = DIR_D;
      KEY_UP:    d = DIR_U;
      default:   d = DIR_L;
    endcase
    return d;
  endfunction

  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr
);

  // Shift right and fold the outgoing bit back through the tap mask every cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/ghost_dir_scheduler.sv
// Per-frame scheduler: shares one wall-lookup port among the ghosts and
// picks each ghost's next direction keycode.
module ghost_dir_scheduler
  import ghost_pkg::*;
#(
  parameter int          NUM_GHOSTS  = 4,
  parameter int          HOLD_FRAMES = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_clk,
  input  logic                          pause,
  output logic                          map_req,
  output logic [$clog2(NUM_GHOSTS)-1:0] map_ghost,
  input  logic                          map_ack,
  input  logic [4:0]                    mapL,
  input  logic [4:0]                    mapR,
  input  logic [4:0]                    mapB,
  input  logic [4:0]                    mapT,
  output logic [8*NUM_GHOSTS-1:0]       ghost_key,
  output logic                          sched_busy
);

  localparam int IDX_W  = $clog2(NUM_GHOSTS);
  localparam int HOLD_W = $clog2(HOLD_FRAMES);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        open_q;      // bit index = dir_e
  logic              pending_q;
  logic              frame_q;
  logic              frame_edge;
  logic              pass_start;
  logic [15:0]       lfsr_val;
  logic              lfsr_unused;

  logic [7:0]        key_q  [NUM_GHOSTS];
  logic [HOLD_W-1:0] hold_q [NUM_GHOSTS];

  logic [7:0]        cur_key, new_key;
  logic [HOLD_W-1:0] cur_hold, new_hold;
  logic              cur_valid;
  dir_e              cur_dir, pick_dir;
  logic [3:0]        cand;
  logic [1:0]        rot;
  logic              found;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .lfsr  (lfsr_val)
  );

  // Only the two low LFSR bits steer the pick; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_val[15:2];

  assign frame_edge = frame_clk & ~frame_q;
  assign map_ghost  = idx_q;

  // Frame strobe history and the one-deep pending-pass flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      if (pass_start) begin
        pending_q <= 1'b0;
      end else if (frame_edge && (state_q != IDLE)) begin
        pending_q <= 1'b1;
      end
    end
  end

  // FSM state, ghost index and captured open-side mask.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      open_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if ((state_q == REQ) && map_ack) begin
        open_q <= {mapT == 5'd0, mapB == 5'd0, mapR == 5'd0, mapL == 5'd0};
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    map_req    = 1'b0;
    sched_busy = 1'b1;
    pass_start = 1'b0;
    case (state_q)
      IDLE: begin
        sched_busy = 1'b0;
        if ((frame_edge || pending_q) && !pause) begin
          state_d    = REQ;
          idx_d      = '0;
          pass_start = 1'b1;
        end
      end
      REQ: begin
        map_req = 1'b1;
        if (map_ack) state_d = DECIDE;
      end
      DECIDE: state_d = NEXT;
      NEXT: begin
        if (idx_q == IDX_W'(NUM_GHOSTS - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Direction choice for the ghost currently being decided.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments so later lines see the values computed above them.
    cur_key   = key_q[idx_q];
    cur_hold  = hold_q[idx_q];
    cur_valid = key_is_dir(cur_key);
    cur_dir   = key_to_dir(cur_key);
    cand      = open_q;
    if (cur_valid) cand[reverse_dir(cur_dir)] = 1'b0;
    if (cand == 4'b0000) cand = open_q;
    pick_dir = DIR_L;
    found    = 1'b0;
    rot      = '0;
    for (int k = 0; k < 4; k++) begin
      rot = lfsr_val[1:0] + 2'(k);
      if (!found && cand[rot]) begin
        pick_dir = dir_e'(rot);
        found    = 1'b1;
      end
    end
    new_key  = cur_key;
    new_hold = '0;
    if (cur_valid && open_q[cur_dir] && (cur_hold != '0)) begin
      new_hold = cur_hold - 1'b1;
    end else if (open_q != 4'b0000) begin
      new_key  = dir_to_key(pick_dir);
      new_hold = HOLD_W'(HOLD_FRAMES - 1);
    end
  end

  // Per-ghost key and hold registers, written once per ghost per pass.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: this small register file is reset because its contents drive ghost motion straight after reset.
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        key_q[i]  <= KEY_NONE;
        hold_q[i] <= '0;
      end
    end else if (state_q == DECIDE) begin
      key_q[idx_q]  <= new_key;
      hold_q[idx_q] <= new_hold;
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_pack
    assign ghost_key[8*g +: 8] = key_q[g];
  end

endmodule

// File: tb/tb_ghost_dir_scheduler.sv
// Self-checking bench for ghost_dir_scheduler with a wall-lookup responder
// and a key-prediction scoreboard.
module tb_ghost_dir_scheduler;
  import ghost_pkg::*;

  localparam int NG   = 4;
  localparam int HOLD = 32;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, pause, map_ack;
  logic [4:0]  mapL, mapR, mapB, mapT;
  logic        map_req, sched_busy;
  logic [1:0]  map_ghost;
  logic [31:0] ghost_key;

  ghost_dir_scheduler #(.NUM_GHOSTS(NG), .HOLD_FRAMES(HOLD), .LFSR_SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pause(pause),
    .map_req(map_req), .map_ghost(map_ghost), .map_ack(map_ack),
    .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
    .ghost_key(ghost_key), .sched_busy(sched_busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference LFSR (textbook Galois form, tap mask 0xB400).
  logic [15:0] m_lfsr;
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Reference ghost state and responder configuration.
  logic [7:0] m_key  [NG];
  int         m_hold [NG];
  logic [4:0] wall   [NG][4];   // side order L, R, D, U
  int         ack_delay [NG];
  int         hs_count = 0;

  typedef struct { int g; logic [7:0] key; } exp_t;
  exp_t sb[$];

  function automatic logic [7:0] side_key(input int d);
    logic [7:0] keys [4];
    keys[0] = 8'h07; keys[1] = 8'h16; keys[2] = 8'h1A; keys[3] = 8'h04;
    return keys[d];
  endfunction

  task automatic model_decide(input int g, input logic [3:0] open, input logic [15:0] lf);
    int cur = -1;
    int start;
    logic [3:0] cand;
    for (int d = 0; d < 4; d++) if (m_key[g] == side_key(d)) cur = d;
    if (cur >= 0 && open[cur] && m_hold[g] > 0) begin
      m_hold[g] = m_hold[g] - 1;
      return;
    end
    if (open == 4'b0) begin
      m_hold[g] = 0;
      return;
    end
    cand = open;
    if (cur == 0) cand[1] = 1'b0;
    if (cur == 1) cand[0] = 1'b0;
    if (cur == 2) cand[3] = 1'b0;
    if (cur == 3) cand[2] = 1'b0;
    if (cand == 4'b0) cand = open;
    start = int'(lf[1:0]);
    for (int k = 3; k >= 0; k--) begin
      if (cand[(start + k) % 4]) m_key[g] = side_key((start + k) % 4);
    end
    m_hold[g] = HOLD - 1;
  endtask

  function automatic logic [31:0] model_keys();
    return {m_key[3], m_key[2], m_key[1], m_key[0]};
  endfunction

  // Responder + scoreboard: one process so driving and observing never race.
  initial begin : responder
    int         wait_cnt = 0;
    logic       hs_prev  = 1'b0;
    int         hs_g     = 0;
    logic [3:0] hs_open  = '0;
    exp_t       e;
    map_ack = 1'b0;
    mapL = '0; mapR = '0; mapB = '0; mapT = '0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        sb.delete();
        hs_prev  = 1'b0;
        wait_cnt = 0;
        map_ack  = 1'b0;
        continue;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("key_g%0d", e.g), 32'(ghost_key[8*e.g +: 8]), 32'(e.key));
      end
      if (hs_prev) begin
        model_decide(hs_g, hs_open, m_lfsr);
        e.g = hs_g;
        e.key = m_key[hs_g];
        sb.push_back(e);
      end
      if (map_req) begin
        if (wait_cnt >= ack_delay[map_ghost]) begin
          map_ack = 1'b1;
          mapL = wall[map_ghost][0]; mapR = wall[map_ghost][1];
          mapB = wall[map_ghost][2]; mapT = wall[map_ghost][3];
        end else begin
          map_ack = 1'b0;
          mapL = 5'($urandom); mapR = 5'($urandom); mapB = 5'($urandom); mapT = 5'($urandom);
        end
        wait_cnt++;
      end else begin
        map_ack  = 1'b0;
        wait_cnt = 0;
      end
      hs_prev = map_req && map_ack;
      if (hs_prev) begin
        hs_g    = int'(map_ghost);
        hs_open = {mapT == 5'd0, mapB == 5'd0, mapR == 5'd0, mapL == 5'd0};
        hs_count++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cnt = 0;
    while (sched_busy && cnt < 200) begin
      cnt++;
      @(negedge Clk);
    end
    if (sched_busy) check({tag, "_timeout"}, 32'(sched_busy), 32'd0);
  endtask

  task automatic run_frame(input string tag);
    pulse_frame();
    wait_idle(tag);
    tick(2);
  endtask

  task automatic set_walls(input int g, input int l, input int r, input int d, input int u);
    wall[g][0] = 5'(l); wall[g][1] = 5'(r); wall[g][2] = 5'(d); wall[g][3] = 5'(u);
  endtask

  task automatic clear_model();
    for (int g = 0; g < NG; g++) begin
      m_key[g]  = 8'h00;
      m_hold[g] = 0;
    end
  endtask

  initial begin : main
    int         cnt;
    int         hs_base;
    logic [7:0] saved;
    Reset = 1'b1; frame_clk = 1'b0; pause = 1'b0;
    clear_model();
    for (int g = 0; g < NG; g++) begin
      ack_delay[g] = 0;
      set_walls(g, 0, 0, 0, 0);
    end
    tick(3);
    check("rst_map_req", 32'(map_req), 32'd0);
    check("rst_map_ghost", 32'(map_ghost), 32'd0);
    check("rst_busy", 32'(sched_busy), 32'd0);
    check("rst_keys", ghost_key, 32'd0);
    Reset = 1'b0;
    tick(2);

    // First pass, all open, zero-wait ack: busy exactly 12 cycles.
    pulse_frame();
    cnt = 0;
    while (sched_busy && cnt < 100) begin
      cnt++;
      @(negedge Clk);
    end
    check("busy_cycles", 32'(cnt), 32'd12);
    tick(2);

    // Held keys, then a left wall for ghost 0.
    run_frame("open2");
    set_walls(0, 3, 0, 0, 0);
    run_frame("left_wall");

    // Dead end for ghost 2, fully walled ghost 3.
    set_walls(2, 3, 0, 3, 3);
    set_walls(3, 1, 2, 3, 4);
    saved = m_key[3];
    run_frame("dead_end");
    check("dead_end_key", 32'(ghost_key[23:16]), 32'h16);
    check("closed_key", 32'(ghost_key[31:24]), 32'(saved));

    // Long random run so hold counters expire and walls vary.
    for (int f = 0; f < 40; f++) begin
      for (int g = 0; g < NG; g++)
        for (int s = 0; s < 4; s++)
          wall[g][s] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      run_frame("random");
    end

    // Delayed ack for ghost 1 plus a frame edge mid-pass.
    for (int g = 0; g < NG; g++) set_walls(g, 0, 0, 0, 0);
    ack_delay[1] = 3;
    pulse_frame();
    cnt = 0;
    while (!(map_req && map_ghost == 2'd1) && cnt < 50) begin
      cnt++;
      @(negedge Clk);
    end
    check("dly_reach_g1", 32'(map_req && map_ghost == 2'd1), 32'd1);
    check("dly_req_0", 32'(map_req), 32'd1);
    check("dly_ghost_0", 32'(map_ghost), 32'd1);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    check("dly_req_1", 32'(map_req), 32'd1);
    check("dly_ghost_1", 32'(map_ghost), 32'd1);
    @(negedge Clk);
    check("dly_req_2", 32'(map_req), 32'd1);
    check("dly_ghost_2", 32'(map_ghost), 32'd1);
    wait_idle("dly_pass1");
    @(negedge Clk);
    check("pending_restart_busy", 32'(sched_busy), 32'd1);
    check("pending_restart_ghost", 32'(map_ghost), 32'd0);
    wait_idle("dly_pass2");
    tick(2);
    ack_delay[1] = 0;

    // Pause: edges ignored and not stored.
    pause = 1'b1;
    hs_base = hs_count;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      repeat (8) begin
        if (map_req) cnt++;
        @(negedge Clk);
      end
    end
    check("pause_no_req", 32'(cnt), 32'd0);
    check("pause_keys", ghost_key, model_keys());
    pause = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (map_req) cnt++;
      @(negedge Clk);
    end
    check("unpause_no_req", 32'(cnt), 32'd0);

    // Pause rising mid-pass: pass completes, no extra pass afterwards.
    hs_base = hs_count;
    pulse_frame();
    tick(2);
    pause = 1'b1;
    wait_idle("pause_mid");
    tick(2);
    check("pause_mid_served", 32'(hs_count - hs_base), 32'd4);
    pulse_frame();
    tick(5);
    pause = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (map_req) cnt++;
      @(negedge Clk);
    end
    check("pause_mid_no_extra", 32'(cnt), 32'd0);
    check("pause_mid_hs", 32'(hs_count - hs_base), 32'd4);

    // Reset while ghost 2 waits in REQ.
    ack_delay[2] = 1000;
    pulse_frame();
    cnt = 0;
    while (!(map_req && map_ghost == 2'd2) && cnt < 50) begin
      cnt++;
      @(negedge Clk);
    end
    check("rst_reach_g2", 32'(map_req && map_ghost == 2'd2), 32'd1);
    Reset = 1'b1;
    clear_model();
    @(negedge Clk);
    check("midrst_map_req", 32'(map_req), 32'd0);
    check("midrst_keys", ghost_key, 32'd0);
    check("midrst_busy", 32'(sched_busy), 32'd0);
    check("midrst_lfsr", 32'(dut.u_lfsr.lfsr), 32'h0000ACE1);
    Reset = 1'b0;
    ack_delay[2] = 0;
    tick(2);
    run_frame("after_rst");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
